// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control encodings,
// the control bundle carried through ID/EX and small decode helpers.
package id_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation class handed to execute
    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'd2;
    localparam logic [1:0] ALU_OP_IMM    = 2'd3;

    // Destination register select and write-back source select
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;

    // Memory access sizes
    localparam logic [2:0] LD_SIZE_W  = 3'd0;
    localparam logic [2:0] LD_SIZE_H  = 3'd1;
    localparam logic [2:0] LD_SIZE_B  = 3'd2;
    localparam logic [2:0] LD_SIZE_HU = 3'd5;
    localparam logic [2:0] LD_SIZE_BU = 3'd6;
    localparam logic [1:0] ST_SIZE_W  = 2'd0;
    localparam logic [1:0] ST_SIZE_H  = 2'd1;
    localparam logic [1:0] ST_SIZE_B  = 2'd2;

    // How the 16-bit immediate is widened
    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_LUI  = 2'd2
    } imm_sel_e;

    // Control bundle carried through ID/EX; all-zero is a bubble
    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] alu_op;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       illegal;
        logic [2:0] ld_size;
        logic [1:0] st_size;
    } ctrl_t;

    function automatic logic [2:0] ld_size_of(input logic [5:0] op);
        case (op)
            OP_LH:   return LD_SIZE_H;
            OP_LB:   return LD_SIZE_B;
            OP_LHU:  return LD_SIZE_HU;
            OP_LBU:  return LD_SIZE_BU;
            default: return LD_SIZE_W;
        endcase
    endfunction

    function automatic logic [1:0] st_size_of(input logic [5:0] op);
        case (op)
            OP_SH:   return ST_SIZE_H;
            OP_SB:   return ST_SIZE_B;
            default: return ST_SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Decode-stage register file: 2**REG_AW x XLEN, two combinational read
// ports, one write port. r0 reads as zero and is never written.
// ID_WB_BYPASS_EN: forward a same-cycle write-back to the read ports.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o
);
    localparam int NREG = 2 ** REG_AW;

    logic [XLEN-1:0] regs_q [NREG];

    // Write port; r0 is left at its reset value forever
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational reads, optionally seeing the write in flight
    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef ID_WB_BYPASS_EN
        if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`else
        // Without bypass the read sees the pre-write value; the compiler
        // keeps producer and consumer far enough apart.
`endif
    end

endmodule

// File: rtl/stage_id_pipe.sv
// MIPS instruction-decode stage: register file, opcode decode, immediate
// widening, load-use hazard detection and the ID/EX pipeline register.
// Optional feature macro: ID_WB_BYPASS_EN (write-back to read bypass, in
// id_regfile).
module stage_id_pipe
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs_data,
    output logic [XLEN-1:0]   ex_rt_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [5:0]        ex_funct,
    output logic [1:0]        ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic [1:0]        ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic              ex_bne,
    output logic              ex_jump,
    output logic              ex_illegal,
    output logic [2:0]        ex_ld_size,
    output logic [1:0]        ex_st_size
);
    // Instruction fields
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [REG_AW-1:0] rs, rt, rd;

    assign op    = id_instr[31:26];
    assign funct = id_instr[5:0];
    assign imm16 = id_instr[15:0];
    assign rs    = REG_AW'(id_instr[25:21]);
    assign rt    = REG_AW'(id_instr[20:16]);
    assign rd    = REG_AW'(id_instr[15:11]);

    logic [XLEN-1:0] rs_rdata, rt_rdata;

    id_regfile #(.XLEN(XLEN), .REG_AW(REG_AW)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rs_rdata),
        .rdata2_o (rt_rdata)
    );

    // Opcode decode into controls, operand usage and immediate kind
    ctrl_t    ctrl;
    logic     uses_rs, uses_rt;
    imm_sel_e imm_sel;

    always_comb begin
        ctrl    = '0;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        imm_sel = IMM_SEXT;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_dst   = REG_DST_RD;
                ctrl.alu_op    = ALU_OP_RTYPE;
                ctrl.reg_write = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = WB_SEL_MEM;
                ctrl.reg_write  = 1'b1;
                ctrl.ld_size    = ld_size_of(op);
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.st_size   = st_size_of(op);
                uses_rt        = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.bne    = (op == OP_BNE);
                ctrl.alu_op = ALU_OP_BRANCH;
                uses_rt     = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_OP_IMM;
                if (op == OP_ANDI || op == OP_ORI) imm_sel = IMM_ZEXT;
                if (op == OP_LUI) begin
                    imm_sel = IMM_LUI;
                    uses_rs = 1'b0;
                end
            end
            OP_J: begin
                ctrl.jump = 1'b1;
                uses_rs   = 1'b0;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RA;
                ctrl.mem_to_reg = WB_SEL_PC;
                uses_rs         = 1'b0;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    // Immediate widening to XLEN; works for any XLEN >= 16, lui result is
    // the 32-bit {imm16,16'b0} sign-extended or truncated to XLEN
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm_ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            case (imm_sel)
                IMM_ZEXT: imm_ext[i] = (i < 16) ? imm16[4'(i % 16)] : 1'b0;
                IMM_LUI:  imm_ext[i] = (i < 16) ? 1'b0 :
                                       (i < 32) ? imm16[4'(i % 16)] : imm16[15];
                default:  imm_ext[i] = (i < 16) ? imm16[4'(i % 16)] : imm16[15];
            endcase
        end
    end

    // ID/EX state
    logic              ex_valid_q,   ex_valid_d;
    logic [PC_W-1:0]   ex_pc_q,      ex_pc_d;
    logic [XLEN-1:0]   ex_rs_data_q, ex_rs_data_d;
    logic [XLEN-1:0]   ex_rt_data_q, ex_rt_data_d;
    logic [XLEN-1:0]   ex_imm_q,     ex_imm_d;
    logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
    logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
    logic [5:0]        ex_funct_q,   ex_funct_d;
    ctrl_t             ex_ctrl_q,    ex_ctrl_d;

    // Load-use hazard against the load sitting in ID/EX; a flush wins
    assign stall = id_valid & ex_valid_q & ex_ctrl_q.mem_read & (ex_rt_q != '0) &
                   ((uses_rs & (rs == ex_rt_q)) | (uses_rt & (rt == ex_rt_q))) &
                   ~flush;

    // Next ID/EX contents: decoded instruction or an all-zero bubble
    always_comb begin
        ex_valid_d   = 1'b0;
        ex_pc_d      = '0;
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        ex_funct_d   = '0;
        ex_ctrl_d    = '0;
        if (id_valid && !flush && !stall) begin
            ex_valid_d   = 1'b1;
            ex_pc_d      = id_pc;
            ex_rs_data_d = rs_rdata;
            ex_rt_data_d = rt_rdata;
            ex_imm_d     = imm_ext;
            ex_rs_d      = rs;
            ex_rt_d      = rt;
            ex_rd_d      = rd;
            ex_funct_d   = funct;
            ex_ctrl_d    = ctrl;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_funct_q   <= '0;
            ex_ctrl_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_funct_q   <= ex_funct_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs_data    = ex_rs_data_q;
    assign ex_rt_data    = ex_rt_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_rd         = ex_rd_q;
    assign ex_funct      = ex_funct_q;
    assign ex_reg_dst    = ex_ctrl_q.reg_dst;
    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_bne        = ex_ctrl_q.bne;
    assign ex_jump       = ex_ctrl_q.jump;
    assign ex_illegal    = ex_ctrl_q.illegal;
    assign ex_ld_size    = ex_ctrl_q.ld_size;
    assign ex_st_size    = ex_ctrl_q.st_size;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Scoreboard bench for stage_id_pipe: each driven cycle pushes the expected
// ID/EX contents, popped and compared one edge later.
module tb_stage_id_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, flush, wb_we;
    logic [31:0] id_instr, id_pc, wb_data;
    logic [4:0]  wb_addr;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic [1:0]  ex_reg_dst, ex_alu_op, ex_mem_to_reg, ex_st_size;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_branch, ex_bne, ex_jump, ex_illegal;
    logic [2:0]  ex_ld_size;

    always #5 clk = ~clk;

    stage_id_pipe #(.XLEN(32), .REG_AW(5), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_bne(ex_bne),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal), .ex_ld_size(ex_ld_size),
        .ex_st_size(ex_st_size)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [1:0]  reg_dst, alu_op, mem_to_reg;
        logic        alu_src, mem_read, mem_write, reg_write;
        logic        branch, bne, jump, illegal;
        logic [2:0]  ld_size;
        logic [1:0]  st_size;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] pc = 32'h0000_0400;

    localparam logic [31:0] I_ADD1 = {6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] I_LW   = {6'h23, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_ADD2 = {6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20};
    localparam logic [31:0] I_J    = {6'h02, 5'd2, 5'd2, 16'h0000};
    localparam logic [31:0] I_LW0  = {6'h23, 5'd1, 5'd0, 16'h0008};
    localparam logic [31:0] I_ADD0 = {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20};
    localparam logic [31:0] I_SW2  = {6'h2B, 5'd1, 5'd2, 16'h0008};
    localparam logic [31:0] I_ADDI = {6'h08, 5'd0, 5'd6, 16'h8000};
    localparam logic [31:0] I_ORI  = {6'h0D, 5'd0, 5'd6, 16'h8000};
    localparam logic [31:0] I_LUI  = {6'h0F, 5'd0, 5'd6, 16'h0001};
    localparam logic [31:0] I_ILL  = {6'h3F, 5'd1, 5'd2, 16'h0000};
    localparam logic [31:0] I_BNE  = {6'h05, 5'd1, 5'd3, 16'hFFFF};
    localparam logic [31:0] I_JAL  = {6'h03, 26'h0000040};
    localparam logic [31:0] I_LBU  = {6'h24, 5'd1, 5'd5, 16'hFFFC};
    localparam logic [31:0] I_SB   = {6'h28, 5'd1, 5'd5, 16'h0002};
    localparam logic [31:0] I_ADD7 = {6'h00, 5'd7, 5'd0, 5'd8, 5'd0, 6'h20};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t dec(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] rsd, input logic [31:0] rtd,
                                 input logic [31:0] imm);
        exp_t e = '0;
        e.valid = 1'b1; e.pc = p; e.rs_data = rsd; e.rt_data = rtd; e.imm = imm;
        e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11]; e.funct = ins[5:0];
        return e;
    endfunction

    function automatic exp_t as_load(input exp_t ein, input logic [2:0] sz);
        exp_t e = ein;
        e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 2'd1; e.reg_write = 1; e.ld_size = sz;
        return e;
    endfunction

    function automatic exp_t as_rtype(input exp_t ein);
        exp_t e = ein;
        e.reg_dst = 2'd1; e.alu_op = 2'd2; e.reg_write = 1;
        return e;
    endfunction

    function automatic exp_t as_imm(input exp_t ein);
        exp_t e = ein;
        e.alu_src = 1; e.reg_write = 1; e.alu_op = 2'd3;
        return e;
    endfunction

    task automatic cmp_ex(input exp_t e);
        chk("ex_valid", ex_valid, e.valid);
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_rs_data", ex_rs_data, e.rs_data);
        chk("ex_rt_data", ex_rt_data, e.rt_data);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_rs", ex_rs, e.rs);
        chk("ex_rt", ex_rt, e.rt);
        chk("ex_rd", ex_rd, e.rd);
        chk("ex_funct", ex_funct, e.funct);
        chk("ex_reg_dst", ex_reg_dst, e.reg_dst);
        chk("ex_alu_op", ex_alu_op, e.alu_op);
        chk("ex_mem_to_reg", ex_mem_to_reg, e.mem_to_reg);
        chk("ex_alu_src", ex_alu_src, e.alu_src);
        chk("ex_mem_read", ex_mem_read, e.mem_read);
        chk("ex_mem_write", ex_mem_write, e.mem_write);
        chk("ex_reg_write", ex_reg_write, e.reg_write);
        chk("ex_branch", ex_branch, e.branch);
        chk("ex_bne", ex_bne, e.bne);
        chk("ex_jump", ex_jump, e.jump);
        chk("ex_illegal", ex_illegal, e.illegal);
        chk("ex_ld_size", ex_ld_size, e.ld_size);
        chk("ex_st_size", ex_st_size, e.st_size);
    endtask

    task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we = we; wb_addr = a; wb_data = d;
    endtask

    // Drive one decode cycle, check stall, queue the expected ID/EX result,
    // then advance one edge and compare against the head of the queue.
    task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                         input logic exp_stall, input exp_t e);
        exp_t h;
        id_valid = v; id_instr = ins; id_pc = pc; flush = fl;
        #1;
        chk("stall", stall, exp_stall);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            h = exp_q.pop_front();
            cmp_ex(h);
        end
        wb_we = 1'b0; flush = 1'b0;
        if (v && !exp_stall && !fl) pc = pc + 4;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset = 1'b1; id_valid = 0; id_instr = 0; id_pc = 0; flush = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        #12;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ex_rs_data", ex_rs_data, 0);
        chk("rst_ex_reg_write", ex_reg_write, 0);
        @(negedge clk);
        reset = 1'b0;

        // r5 = 0x1234, then add r3,r5,r0
        set_wb(1, 5, 32'h1234); drive(0, 0, 0, 0, '0);
        drive(1, I_ADD1, 0, 0, as_rtype(dec(I_ADD1, pc, 32'h1234, 0, 32'h0000_1820)));

        // r1 = 0x100, r3 = 7; lw r2,4(r1) then dependent add: one bubble
        set_wb(1, 1, 32'h100); drive(0, 0, 0, 0, '0);
        set_wb(1, 3, 32'h7);   drive(0, 0, 0, 0, '0);
        drive(1, I_LW, 0, 0, as_load(dec(I_LW, pc, 32'h100, 0, 32'h4), 3'd0));
        drive(1, I_ADD2, 0, 1, '0);
        drive(1, I_ADD2, 0, 0, as_rtype(dec(I_ADD2, pc, 0, 32'h7, 32'h2020)));

        // lw r2 followed by j (no rs/rt use) and lw r0 followed by r0 use
        drive(1, I_LW, 0, 0, as_load(dec(I_LW, pc, 32'h100, 0, 32'h4), 3'd0));
        e = dec(I_J, pc, 0, 0, 0); e.jump = 1;
        drive(1, I_J, 0, 0, e);
        drive(1, I_LW0, 0, 0, as_load(dec(I_LW0, pc, 32'h100, 0, 32'h8), 3'd0));
        drive(1, I_ADD0, 0, 0, as_rtype(dec(I_ADD0, pc, 0, 0, 32'h2020)));

        // lw r2 then sw r2 (rt use) stalls once
        drive(1, I_LW, 0, 0, as_load(dec(I_LW, pc, 32'h100, 0, 32'h4), 3'd0));
        drive(1, I_SW2, 0, 1, '0);
        e = dec(I_SW2, pc, 32'h100, 0, 32'h8); e.alu_src = 1; e.mem_write = 1;
        drive(1, I_SW2, 0, 0, e);

        // flush during a load-use stall
        drive(1, I_LW, 0, 0, as_load(dec(I_LW, pc, 32'h100, 0, 32'h4), 3'd0));
        id_valid = 1; id_instr = I_ADD2; flush = 0;
        #1;
        chk("stall_pre_flush", stall, 1);
        drive(1, I_ADD2, 1, 0, '0);
        pc = pc + 4;

        // immediate extension and illegal opcode
        drive(1, I_ADDI, 0, 0, as_imm(dec(I_ADDI, pc, 0, 0, 32'hFFFF_8000)));
        drive(1, I_ORI, 0, 0, as_imm(dec(I_ORI, pc, 0, 0, 32'h0000_8000)));
        drive(1, I_LUI, 0, 0, as_imm(dec(I_LUI, pc, 0, 0, 32'h0001_0000)));
        e = dec(I_ILL, pc, 32'h100, 0, 0); e.illegal = 1;
        drive(1, I_ILL, 0, 0, e);

        // bne, jal, lbu then sb using the loaded register
        e = dec(I_BNE, pc, 32'h100, 32'h7, 32'hFFFF_FFFF);
        e.branch = 1; e.bne = 1; e.alu_op = 2'd1;
        drive(1, I_BNE, 0, 0, e);
        e = dec(I_JAL, pc, 0, 0, 32'h40);
        e.jump = 1; e.reg_write = 1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
        drive(1, I_JAL, 0, 0, e);
        drive(1, I_LBU, 0, 0, as_load(dec(I_LBU, pc, 32'h100, 32'h1234, 32'hFFFF_FFFC), 3'd6));
        drive(1, I_SB, 0, 1, '0);
        e = dec(I_SB, pc, 32'h100, 32'h1234, 32'h2);
        e.alu_src = 1; e.mem_write = 1; e.st_size = 2'd2;
        drive(1, I_SB, 0, 0, e);

        // same-cycle write-back and read of r7
        set_wb(1, 7, 32'h1); drive(0, 0, 0, 0, '0);
        set_wb(1, 7, 32'hBEEF);
`ifdef ID_WB_BYPASS_EN
        drive(1, I_ADD7, 0, 0, as_rtype(dec(I_ADD7, pc, 32'hBEEF, 0, 32'h4020)));
`else
        drive(1, I_ADD7, 0, 0, as_rtype(dec(I_ADD7, pc, 32'h1, 0, 32'h4020)));
`endif
        drive(1, I_ADD7, 0, 0, as_rtype(dec(I_ADD7, pc, 32'hBEEF, 0, 32'h4020)));

        // reset asserted in the middle of a stall cycle
        drive(1, I_LW, 0, 0, as_load(dec(I_LW, pc, 32'h100, 0, 32'h4), 3'd0));
        id_valid = 1; id_instr = I_ADD2;
        #1;
        chk("stall_before_reset", stall, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("stall_in_reset", stall, 0);
        chk("ex_valid_in_reset", ex_valid, 0);
        chk("ex_mem_read_in_reset", ex_mem_read, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, I_LW, 0, 0, as_load(dec(I_LW, pc, 0, 0, 32'h4), 3'd0));

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stage_id_pipe.md
# stage_id_pipe

Parametrised instruction-decode stage for the 5-stage MIPS pipeline; it sits between the IF/ID register and the execute stage. It holds the register file, decodes the opcode into execute, memory and write-back controls, and sign-/zero-extends the immediate. It also detects load-use hazards and registers everything into the ID/EX pipeline register. Unlike the previous decode stage, it has a valid bit, bubble insertion on stall or flush, a reset, and configurable data width and register count.

## Interface
Parameters:
- XLEN, 32, datapath width (≥ 16)
- REG_AW, 5, register address width; the file holds 2**REG_AW registers
- PC_W, 32, program-counter width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  IF/ID holds a real instruction
- id_instr  in  32  instruction word (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0])
- id_pc  in  PC_W  PC+4 of the instruction
- flush  in  1  branch/jump redirect from a later stage; kills the instruction in decode
- wb_we, wb_addr, wb_data  in  1/REG_AW/XLEN  write-back port
- stall  out  1  combinational; holds the PC and IF/ID for this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  PC_W/XLEN/XLEN/XLEN
- ex_rs, ex_rt, ex_rd  out  REG_AW each
- ex_funct  out  6
- ex_reg_dst, ex_alu_op, ex_mem_to_reg  out  2 each
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_bne, ex_jump, ex_illegal  out  1 each
- ex_ld_size  out  3  (0 word, 1 half, 2 byte, 5 half-unsigned, 6 byte-unsigned)
- ex_st_size  out  2  (0 word, 1 half, 2 byte)

## Operation
- Reset: all ID/EX outputs go to 0; all registers go to 0; stall=0.
- Register file:
  - 2**REG_AW × XLEN.
  - Register 0 always reads 0, and writes to it are ignored.
  - Write happens on the rising edge when wb_we=1 and wb_addr≠0.
  - Reads are combinational.
- Decode:
  - Opcode 0x00 (R-type): reg_dst=1, alu_op=2, reg_write=1.
  - Loads 0x20/0x21/0x23/0x24/0x25: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, ld_size as listed in Interface.
  - Stores 0x28/0x29/0x2B: alu_src=1, mem_write=1, st_size as listed in Interface.
  - 0x04 beq: branch=1, alu_op=1.
  - 0x05 bne: branch=1, bne=1, alu_op=1.
  - 0x08/0x0A addi/slti: alu_src=1, reg_write=1, alu_op=3.
  - 0x0C/0x0D andi/ori: same controls, but the immediate is zero-extended.
  - 0x0F lui: alu_src=1, reg_write=1, alu_op=3, imm = {imm16, 16'b0} sign-extended to XLEN.
  - 0x02 j: jump=1.
  - 0x03 jal: jump=1, reg_write=1, reg_dst=2 (r31), mem_to_reg=2.
  - Any other opcode: all controls 0 and ex_illegal=1.
  - Otherwise the immediate is sign-extended imm16 to XLEN.
- Operand use:
  - uses_rs for all opcodes except j, jal and lui.
  - uses_rt for R-type, stores, beq and bne.
- Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & ex_rt≠0 & ((uses_rs & rs==ex_rt) | (uses_rt & rt==ex_rt)) & ~flush.
- ID/EX update on every edge:
  - If flush or stall or ~id_valid: load a bubble (ex_valid=0, every control and ex_illegal = 0; data fields don't-care, implemented as 0).
  - Otherwise load the decoded instruction with ex_valid=1.
- Precedence: flush has priority over stall; a flush forces stall=0.

## Timing
- Decode latency: 1 cycle, from id_* to ex_*.
- Load-use stall: exactly 1 cycle. In the next cycle ID/EX holds the bubble (ex_mem_read=0), so stall deasserts and the held instruction issues.
- stall is a combinational function of the current id_* inputs and the ID/EX state; it has no registered delay.
- A write-back and a decode read of the same register in the same cycle are resolved as described under Configuration.
- Reset asserted mid-stall: stall drops immediately and ID/EX clears asynchronously.

## Configuration
- ID_WB_BYPASS_EN defined: when wb_we=1 and wb_addr equals a nonzero rs or rt in the same cycle, the read returns wb_data (write-before-read).
- ID_WB_BYPASS_EN undefined: the read returns the pre-write value, and the compiler must separate the instructions by 3 slots.

## Structure
- Package id_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, ...)
  - ALU_OP_* codes
  - LD_SIZE_* and ST_SIZE_* encodings
  - a ctrl_t struct for the control bundle
- One sub-module: id_regfile (parametrised XLEN/REG_AW, with the bypass under the macro).
- Decode, hazard detection and the ID/EX register live in stage_id_pipe.

## Test plan
- Reset, then write r5=0x1234 via WB. Decode add r3,r5,r0 (funct 0x20) → next cycle ex_valid=1, ex_rs_data=0x1234, ex_reg_dst=1, ex_alu_op=2, ex_funct=0x20.
- lw r2,4(r1) followed by add r4,r2,r3:
  - stall=1 for one cycle and ex_valid=0 for one cycle.
  - The add then issues with ex_rs=2; total 3 cycles from lw decode to add in EX.
- lw r2 followed by j, or lw r0 followed by a use of r0 → stall never asserts.
- Assert flush during the stall cycle → stall=0, bubble loaded, next id instruction decoded normally.
- Write r7 and read r7 in the same cycle with wb_data=0xBEEF, old value 0x1 → ex_rs_data=0xBEEF with ID_WB_BYPASS_EN defined, 0x1 without it.
- Immediate extension:
  - addi with imm 0x8000 → ex_imm=0xFFFF8000.
  - ori with imm 0x8000 → 0x00008000.
  - lui with imm 0x1 → 0x00010000.
  - opcode 0x3F → ex_illegal=1 and all other controls 0.
